// File: rtl/main_mem_loader.sv
// main_mem_loader: streams an initial memory image into main's channel-0 slave
// RAM port (word-packed, little-endian), then starts main and measures the
// number of cycles until done_port, aborting on a cycle-count timeout.
module main_mem_loader #(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic                  load_start,
  input  logic                  in_byte_valid,
  input  logic [7:0]            in_byte_data,
  input  logic                  in_byte_last,
  output logic                  in_byte_ready,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [127:0]          S_Wdata_ram,
  output logic [13:0]           S_data_ram_size,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  start_port,
  input  logic                  done_port,
  output logic                  busy,
  output logic                  result_valid,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  timeout
);

  // Byte index k counts 0..WORD_BYTES inclusive.
  localparam int unsigned KW     = $clog2(WORD_BYTES + 1);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_START,
    S_RUN,
    S_REPORT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [KW-1:0]       k_q, k_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SIZE_W-1:0]   wsize_q, wsize_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                rvalid_q, rvalid_d;

  // Channel 1 acknowledge is never used by this loader.
  logic                unused_rdy_hi;
  assign unused_rdy_hi = Sout_DataRdy[1];

  // State and datapath registers; reset abandons any in-flight write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      buf_q     <= '0;
      k_q       <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wsize_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      k_q       <= k_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wsize_q   <= wsize_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register
  // in step with the state they belong to.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    k_d       = k_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          addr_d  = cfg_base_addr;
          buf_d   = '0;
          k_d     = '0;
          last_d  = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_byte_valid) begin
          for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            if (k_q == KW'(b)) buf_d[8*b +: 8] = in_byte_data;
          end
          k_d    = k_q + KW'(1);
          last_d = in_byte_last;
          if ((k_d == KW'(WORD_BYTES)) || in_byte_last) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (Sout_DataRdy[0]) begin
          addr_d = addr_q + ADDR_W'(k_q);
          buf_d  = '0;
          k_d    = '0;
          last_d = 1'b0;
          if (last_q) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = S_START;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_START: begin
        cnt_d   = CNT_W'(1);
        state_d = S_RUN;
      end

      S_RUN: begin
        if (done_port) begin
          state_d = S_REPORT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = S_REPORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d  = (state_d == S_LOAD);
    we_d     = (state_d == S_WRITE);
    waddr_d  = we_d ? addr_d : '0;
    wdata_d  = we_d ? buf_d : '0;
    wsize_d  = we_d ? SIZE_W'({k_d, 3'b000}) : '0;
    start_d  = (state_d == S_START);
    busy_d   = (state_d != S_IDLE);
    rvalid_d = (state_d == S_REPORT);
  end

  assign in_byte_ready   = ready_q;
  assign S_oe_ram        = 2'b00;
  assign S_we_ram        = {1'b0, we_q};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, waddr_q};
  assign S_Wdata_ram     = {64'd0, wdata_q};
  assign S_data_ram_size = {7'd0, wsize_q};
  assign start_port      = start_q;
  assign busy            = busy_q;
  assign result_valid    = rvalid_q;
  assign cycle_count     = cnt_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_main_mem_loader.sv
// Bench for main_mem_loader: table of image/run vectors plus hand-written
// backpressure and reset-during-write sequences.
module tb_main_mem_loader;

  localparam int unsigned WB = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 32;
  localparam int unsigned TO = 50;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     cfg_base_addr = '0;
  logic              load_start = 1'b0;
  logic              in_byte_valid = 1'b0;
  logic [7:0]        in_byte_data = '0;
  logic              in_byte_last = 1'b0;
  logic              in_byte_ready;
  logic [1:0]        S_oe_ram;
  logic [1:0]        S_we_ram;
  logic [2*AW-1:0]   S_addr_ram;
  logic [127:0]      S_Wdata_ram;
  logic [13:0]       S_data_ram_size;
  logic [1:0]        Sout_DataRdy = 2'b01;
  logic              start_port;
  logic              done_port = 1'b0;
  logic              busy;
  logic              result_valid;
  logic [CW-1:0]     cycle_count;
  logic              timeout;

  main_mem_loader #(
    .WORD_BYTES(WB), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .cfg_base_addr(cfg_base_addr),
    .load_start(load_start), .in_byte_valid(in_byte_valid),
    .in_byte_data(in_byte_data), .in_byte_last(in_byte_last),
    .in_byte_ready(in_byte_ready), .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram),
    .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size), .Sout_DataRdy(Sout_DataRdy),
    .start_port(start_port), .done_port(done_port), .busy(busy),
    .result_valid(result_valid), .cycle_count(cycle_count), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [6:0]    size;
    logic          hi_zero;
  } w_t;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    logic [7:0]    first;
    int            done_dly;   // 0 = never assert done
    int            nwr;
    logic [AW-1:0] a0;
    logic [63:0]   d0;
    logic [6:0]    s0;
    logic [AW-1:0] a1;
    logic [63:0]   d1;
    logic [6:0]    s1;
    logic [31:0]   cnt;
    logic          to;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  w_t   wrq[$];
  int   acc_q[$];
  int   st_q[$];
  vec_t vecs[6];

  always @(posedge clock) cyc <= cyc + 1;

  // Observe completed writes, accepted bytes and start pulses.
  always @(negedge clock) begin
    w_t w;
    if (!reset) begin
      if (in_byte_valid && in_byte_ready) acc_q.push_back(cyc + 1);
      if (start_port) st_q.push_back(cyc);
      if (S_we_ram[0] && Sout_DataRdy[0]) begin
        w.addr    = S_addr_ram[AW-1:0];
        w.data    = S_Wdata_ram[63:0];
        w.size    = S_data_ram_size[6:0];
        w.hi_zero = (S_addr_ram[2*AW-1:AW] == '0) && (S_Wdata_ram[127:64] == '0) &&
                    (S_data_ram_size[13:7] == '0) && (S_oe_ram == 2'b00) && !S_we_ram[1];
        wrq.push_back(w);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request a load and stream n incrementing bytes starting at 'first'.
  task automatic feed(input logic [AW-1:0] base, input int n, input logic [7:0] first);
    logic ok;
    load_start    = 1'b1;
    cfg_base_addr = base;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_byte_valid = 1'b1;
      in_byte_data  = first + 8'(i);
      in_byte_last  = (i == n - 1);
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
        @(negedge clock);
        ok = in_byte_ready;
        @(posedge clock);
        #1;
      end
      if (!ok) chk("byte_accept_bound", 64'd0, 64'd1);
    end
    in_byte_valid = 1'b0;
    in_byte_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   wb, ab, sb, exp_lat;
    logic found;
    logic [AW-1:0] ea;
    logic [63:0]   ed;
    logic [6:0]    es;
    wb = wrq.size();
    ab = acc_q.size();
    sb = st_q.size();
    feed(v.base, v.n, v.first);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (start_port) found = 1'b1;
      else tick();
    end
    chk({tag, "_start_seen"}, 64'(found), 64'd1);
    tick();
    chk({tag, "_start_width"}, 64'(start_port), 64'd0);
    chk({tag, "_run1_count"}, 64'(cycle_count), 64'd1);
    if (v.done_dly > 0) begin
      repeat (v.done_dly - 1) tick();
      done_port = 1'b1;
      tick();
      done_port = 1'b0;
    end else begin
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
        if (result_valid) found = 1'b1;
        else tick();
      end
    end
    chk({tag, "_result_valid"}, 64'(result_valid), 64'd1);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(v.cnt));
    chk({tag, "_timeout"}, 64'(timeout), 64'(v.to));
    tick();
    chk({tag, "_rv_pulse"}, 64'(result_valid), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_count_held"}, 64'(cycle_count), 64'(v.cnt));
    chk({tag, "_timeout_held"}, 64'(timeout), 64'(v.to));
    chk({tag, "_n_writes"}, 64'(wrq.size() - wb), 64'(v.nwr));
    for (int j = 0; j < v.nwr; j++) begin
      ea = (j == 0) ? v.a0 : v.a1;
      ed = (j == 0) ? v.d0 : v.d1;
      es = (j == 0) ? v.s0 : v.s1;
      if (wrq.size() > wb + j) begin
        chk({tag, "_waddr"}, 64'(wrq[wb+j].addr), 64'(ea));
        chk({tag, "_wdata"}, wrq[wb+j].data, ed);
        chk({tag, "_wsize"}, 64'(wrq[wb+j].size), 64'(es));
        chk({tag, "_upper_zero"}, 64'(wrq[wb+j].hi_zero), 64'd1);
      end
    end
    chk({tag, "_n_starts"}, 64'(st_q.size() - sb), 64'd1);
    exp_lat = v.n + (v.n + int'(WB) - 1) / int'(WB) - 1;
    if (st_q.size() > sb && acc_q.size() > ab)
      chk({tag, "_latency"}, 64'(st_q[sb] - acc_q[ab]), 64'(exp_lat));
    else
      chk({tag, "_latency_events"}, 64'd0, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t clean;
    int   wb;
    vecs[0] = '{10'h000, 1, 8'hA5, 1,  1, 10'h000, 64'hA5,       7'd8,  10'h000, 64'h0,        7'd0,  32'd1,  1'b0};
    vecs[1] = '{10'h100, 6, 8'h01, 17, 2, 10'h100, 64'h04030201, 7'd32, 10'h104, 64'h0605,     7'd16, 32'd17, 1'b0};
    vecs[2] = '{10'h3FE, 4, 8'h10, 5,  1, 10'h3FE, 64'h13121110, 7'd32, 10'h000, 64'h0,        7'd0,  32'd5,  1'b0};
    vecs[3] = '{10'h3FE, 5, 8'h10, 2,  2, 10'h3FE, 64'h13121110, 7'd32, 10'h002, 64'h14,       7'd8,  32'd2,  1'b0};
    vecs[4] = '{10'h020, 8, 8'hF0, 0,  2, 10'h020, 64'hF3F2F1F0, 7'd32, 10'h024, 64'hF7F6F5F4, 7'd32, 32'd50, 1'b1};
    vecs[5] = '{10'h3FF, 3, 8'h7E, 3,  1, 10'h3FF, 64'h00807F7E, 7'd24, 10'h000, 64'h0,        7'd0,  32'd3,  1'b0};
    clean   = '{10'h010, 1, 8'h5A, 4,  1, 10'h010, 64'h5A,       7'd8,  10'h000, 64'h0,        7'd0,  32'd4,  1'b0};

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_we", 64'(S_we_ram), 64'd0);
    chk("rst_oe", 64'(S_oe_ram), 64'd0);
    chk("rst_addr", 64'(S_addr_ram), 64'd0);
    chk("rst_wdata", 64'(|S_Wdata_ram), 64'd0);
    chk("rst_size", 64'(S_data_ram_size), 64'd0);
    chk("rst_start", 64'(start_port), 64'd0);
    chk("rst_ready", 64'(in_byte_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Table of images and runs with zero-wait acknowledge
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Write backpressure: acknowledge withheld for 3 cycles
    Sout_DataRdy = 2'b00;
    wb = wrq.size();
    feed(10'h040, 4, 8'hA0);
    for (int j = 0; j < 4; j++) begin
      if (j == 3) Sout_DataRdy = 2'b01;
      chk("bp_we", 64'(S_we_ram), 64'd1);
      chk("bp_addr", 64'(S_addr_ram), 64'h040);
      chk("bp_data", S_Wdata_ram[63:0], 64'hA3A2A1A0);
      chk("bp_size", 64'(S_data_ram_size), 64'd32);
      chk("bp_ready", 64'(in_byte_ready), 64'd0);
      tick();
    end
    chk("bp_we_drop", 64'(S_we_ram), 64'd0);
    chk("bp_start", 64'(start_port), 64'd1);
    chk("bp_n_writes", 64'(wrq.size() - wb), 64'd1);
    tick();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
    chk("bp_rv", 64'(result_valid), 64'd1);
    chk("bp_count_first_run", 64'(cycle_count), 64'd1);
    chk("bp_timeout", 64'(timeout), 64'd0);
    tick();
    tick();

    // Reset asserted mid-write, then a clean load
    Sout_DataRdy = 2'b00;
    feed(10'h200, 2, 8'h11);
    chk("rw_we_before", 64'(S_we_ram), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_we_async", 64'(S_we_ram), 64'd0);
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_addr", 64'(S_addr_ram), 64'd0);
    chk("rw_count", 64'(cycle_count), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    Sout_DataRdy = 2'b01;
    tick();
    run_vec(clean, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/main_mem_loader.md
Name: main_mem_loader

Overview:
- Synthesizable front-end that sits directly upstream of the HLS-generated `main` accelerator.
- Consumes a byte stream of initial memory contents and writes it into `main`'s slave RAM port (channel 0), word-packed.
- It then pulses start_port and counts clock cycles until done_port, with a timeout.
- It replaces the file-driven memory initialisation and cycle measurement of the simulation bench, for on-board runs.

Parameters:
- WORD_BYTES, 4, bytes packed per slave write (1..8).
- ADDR_W, 10, width of one channel's slice of S_addr_ram.
- CNT_W, 32, width of cycle_count.
- TIMEOUT_CYCLES, 200000000, run aborts when cycle_count reaches this value.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_base_addr  in  ADDR_W  byte address of the first byte; sampled on load_start.
- load_start  in  1  one-cycle request; honoured only in IDLE.
- in_byte_valid  in  1  stream byte valid.
- in_byte_data  in  8  stream byte.
- in_byte_last  in  1  marks the final byte of the image.
- in_byte_ready  out  1  byte accepted when valid&ready.
- S_oe_ram  out  2  always 0.
- S_we_ram  out  2  bit0 = write strobe, channel 0; bit1 always 0.
- S_addr_ram  out  2*ADDR_W  [ADDR_W-1:0] = write byte address; upper half 0.
- S_Wdata_ram  out  128  [63:0] = packed word; upper half 0.
- S_data_ram_size  out  14  [6:0] = write size in bits; upper half 0.
- Sout_DataRdy  in  2  bit0 = channel-0 write acknowledge.
- start_port  out  1  start pulse to main.
- done_port  in  1  completion from main.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle pulse; cycle_count and timeout valid.
- cycle_count  out  CNT_W  measured run length; held until next result.
- timeout  out  1  run aborted by timeout; held with cycle_count.

Behaviour:
- Reset values:
  - All S_* outputs, start_port, in_byte_ready, busy, result_valid, timeout: 0.
  - cycle_count: 0.
  - State: IDLE.
  - Packing buffer and byte index: 0.
- Reset asserted in any state returns immediately to the reset values. Any in-flight write is abandoned; S_we_ram drops asynchronously.
- States: IDLE, LOAD, WRITE, START, RUN, REPORT.
- IDLE → LOAD on load_start. Capture cfg_base_addr into the address register; clear byte index k.
- LOAD:
  - in_byte_ready = 1.
  - On each accepted byte, store it at buffer bits [8k+7:8k] (little-endian) and increment k.
  - Go to WRITE when k reaches WORD_BYTES or the accepted byte has in_byte_last.
- WRITE:
  - in_byte_ready = 0.
  - S_we_ram[0] = 1, S_addr_ram = address register, S_Wdata_ram[63:0] = buffer with unused bytes 0, S_data_ram_size[6:0] = 8*k.
  - All held stable until Sout_DataRdy[0] is sampled high; that cycle is the last cycle of the write.
  - On acknowledge: add k to the address (modulo 2^ADDR_W, wrap silently), clear buffer and k.
  - Go to START if the word contained last, else back to LOAD.
  - A zero-wait acknowledge (DataRdy high in the first WRITE cycle) gives a one-cycle write.
- START:
  - start_port = 1 for exactly one cycle.
  - cycle_count cleared to 0.
  - Go to RUN.
- RUN:
  - cycle_count increments every cycle; the first RUN cycle holds 1.
  - done_port sampled high: go to REPORT with cycle_count = number of cycles since the START cycle. Done in the first RUN cycle gives 1.
  - Otherwise, when cycle_count == TIMEOUT_CYCLES: set timeout = 1 and go to REPORT.
  - If done_port and timeout coincide, done wins and timeout = 0.
- REPORT:
  - result_valid = 1 for one cycle.
  - Go to IDLE.
  - cycle_count and timeout hold until the next START cycle; timeout clears there.
- done_port outside RUN is ignored.
- load_start outside IDLE is ignored.
- in_byte_valid outside LOAD is ignored; no byte is consumed.
- Sout_DataRdy outside WRITE is ignored.
- Latency, with one byte per cycle and zero-wait acknowledge: an N-byte image takes N + ceil(N/WORD_BYTES) cycles from the first byte accept to the START cycle.

Test Plan:
- Single-byte image:
  - Stimulus: base=0x000, byte 0xA5 with last, DataRdy high immediately.
  - Response: one write with addr 0, Wdata[63:0]=0x00000000000000A5, size=8. Then start_port pulses for one cycle.
- Multi-word packing:
  - Stimulus: 6 bytes 0x01..0x06 from base=0x100, WORD_BYTES=4.
  - Response: write addr 0x100, data 0x04030201, size 32; then write addr 0x104, data 0x0605, size 16.
- Write backpressure:
  - Stimulus: hold Sout_DataRdy[0] low for 3 cycles.
  - Response: addr, data and we stay stable for 4 cycles; in_byte_ready stays 0 throughout.
- Run measurement:
  - Stimulus: done_port asserted 17 cycles after the start_port cycle.
  - Response: result_valid pulse with cycle_count=17, timeout=0. Done in the first RUN cycle gives 1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50, done_port never asserted.
  - Response: result_valid with cycle_count=50, timeout=1; state returns to IDLE.
- Reset and address wrap:
  - Stimulus: reset during WRITE.
  - Response: S_we_ram=0 immediately, busy=0; the next load starts cleanly.
  - Stimulus: base=0x3FE, 4 bytes, ADDR_W=10.
  - Response: a single write at 0x3FE; the next address register value is 0x002.
